// File: rtl/morse_pkg.sv
// Shared types, widths and the A-Z Morse lookup table for the letter transmitter.
package morse_pkg;

  localparam int PAT_W = 16;
  localparam int LEN_W = 5;
  localparam logic [4:0] LETTER_COUNT = 5'd26;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // Packed so that the struct reads as {len, pattern}
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pattern;
  } morse_code_t;

  // Each symbol carries its own trailing off unit: dot = "10", dash = "1110".
  // The table holds the raw right-justified bits, which are left-justified on return.
  function automatic morse_code_t morse_lookup(input logic [4:0] letter);
    morse_code_t      res;
    logic [PAT_W-1:0] raw;
    logic [LEN_W-1:0] len;
    unique case (letter)
      5'd0:  begin raw = 16'b101110;         len = 5'd6;  end
      5'd1:  begin raw = 16'b1110101010;     len = 5'd10; end
      5'd2:  begin raw = 16'b111010111010;   len = 5'd12; end
      5'd3:  begin raw = 16'b11101010;       len = 5'd8;  end
      5'd4:  begin raw = 16'b10;             len = 5'd2;  end
      5'd5:  begin raw = 16'b1010111010;     len = 5'd10; end
      5'd6:  begin raw = 16'b1110111010;     len = 5'd10; end
      5'd7:  begin raw = 16'b10101010;       len = 5'd8;  end
      5'd8:  begin raw = 16'b1010;           len = 5'd4;  end
      5'd9:  begin raw = 16'b10111011101110; len = 5'd14; end
      5'd10: begin raw = 16'b1110101110;     len = 5'd10; end
      5'd11: begin raw = 16'b1011101010;     len = 5'd10; end
      5'd12: begin raw = 16'b11101110;       len = 5'd8;  end
      5'd13: begin raw = 16'b111010;         len = 5'd6;  end
      5'd14: begin raw = 16'b111011101110;   len = 5'd12; end
      5'd15: begin raw = 16'b101110111010;   len = 5'd12; end
      5'd16: begin raw = 16'b11101110101110; len = 5'd14; end
      5'd17: begin raw = 16'b10111010;       len = 5'd8;  end
      5'd18: begin raw = 16'b101010;         len = 5'd6;  end
      5'd19: begin raw = 16'b1110;           len = 5'd4;  end
      5'd20: begin raw = 16'b10101110;       len = 5'd8;  end
      5'd21: begin raw = 16'b1010101110;     len = 5'd10; end
      5'd22: begin raw = 16'b1011101110;     len = 5'd10; end
      5'd23: begin raw = 16'b111010101110;   len = 5'd12; end
      5'd24: begin raw = 16'b11101011101110; len = 5'd14; end
      5'd25: begin raw = 16'b111011101010;   len = 5'd12; end
      default: begin raw = '0;               len = '0;    end
    endcase
    res.len     = len;
    res.pattern = raw << (PAT_W - int'(len));
    return res;
  endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// Morse unit timebase: counts DIV-1 down to 0 and flags the terminal cycle.
module morse_unit_tick #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Reload on clear or after the terminal count, otherwise step down by one
  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (clear_i || (cnt_q == '0)) begin
      cnt_d = LOAD;
    end
  end

  // Counter register, parked at the reload value out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0) && !clear_i;

endmodule

// File: rtl/morse_letter_tx.sv
// Sends one Morse letter A-Z per request, with inter-letter gap, handshake and repeat.
module morse_letter_tx #(
  parameter int DIV       = 25_000_000,
  parameter int GAP_UNITS = 2
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       Start,
  input  logic [4:0] Letter,
  input  logic       Repeat,
  output logic       DotDashOut,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  import morse_pkg::*;

  localparam int GW = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;

  state_t           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] shift_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bitsLeft_q;
  logic [GW-1:0]    gapLeft_q;
  logic             out_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;

  logic        tick;
  logic        tickClear;
  logic        finish;
  morse_code_t code;

  assign code      = morse_lookup(Letter);
  assign tickClear = (state_q == IDLE);

  morse_unit_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk_i  (ClockIn),
    .rst_ni (Resetn),
    .clear_i(tickClear),
    .tick_o (tick)
  );

  // Letter completes on the unit boundary after its last bit (no gap) or its last gap unit
  always_comb begin
    finish = 1'b0;
    if (tick) begin
      if ((state_q == SEND) && (bitsLeft_q == '0) && (GAP_UNITS == 0)) begin
        finish = 1'b1;
      end
      if ((state_q == GAP) && (gapLeft_q == '0)) begin
        finish = 1'b1;
      end
    end
  end

  // Control FSM with the shift register, bit/gap counters and registered outputs
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      shift_q    <= '0;
      len_q      <= '0;
      bitsLeft_q <= '0;
      gapLeft_q  <= '0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            if (Letter < LETTER_COUNT) begin
              pat_q      <= code.pattern;
              len_q      <= code.len;
              out_q      <= code.pattern[PAT_W-1];
              shift_q    <= code.pattern << 1;
              bitsLeft_q <= code.len - LEN_W'(1);
              busy_q     <= 1'b1;
              state_q    <= SEND;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (tick) begin
            if (bitsLeft_q != '0) begin
              out_q      <= shift_q[PAT_W-1];
              shift_q    <= shift_q << 1;
              bitsLeft_q <= bitsLeft_q - LEN_W'(1);
            end else if (GAP_UNITS > 0) begin
              out_q     <= 1'b0;
              gapLeft_q <= GW'(GAP_UNITS - 1);
              state_q   <= GAP;
            end
          end
        end
        GAP: begin
          if (tick && (gapLeft_q != '0)) begin
            gapLeft_q <= gapLeft_q - GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      if (finish) begin
        done_q <= 1'b1;
        if (Repeat) begin
          out_q      <= pat_q[PAT_W-1];
          shift_q    <= pat_q << 1;
          bitsLeft_q <= len_q - LEN_W'(1);
          state_q    <= SEND;
        end else begin
          out_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end

  assign DotDashOut = out_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Error      = error_q;

endmodule
